// File: rtl/fetch_unit_pkg.sv
// Shared types and widths for the instruction fetch stage.
// State encodings are fixed so they line up with the rest of the CPU.
package fetch_unit_pkg;

  // CPU instruction word width.
  localparam int unsigned WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StValid = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PcHold = 2'd0,
    PcLoad = 2'd1,
    PcIncr = 2'd2
  } pc_sel_e;

  function automatic logic is_req_state(fetch_state_e st);
    return (st == StFetch) || (st == StDrain);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: redirect from execute, instruction memory req/ack, decode valid/ready.
// master is the fetch stage; slave is the memory/decode/execute side.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = fetch_unit_pkg::WORD_WIDTH
);

  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [DATA_WIDTH-1:0] imem_rdata;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with hold / load / increment select.
// Increment wraps modulo 2^ADDR_WIDTH.
module fetch_unit_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  pc_sel_e               sel,
  input  logic [ADDR_WIDTH-1:0] load_pc,
  output logic [ADDR_WIDTH-1:0] pc
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    case (sel)
      PcLoad:  pc_d = load_pc;
      PcIncr:  pc_d = pc_q + ADDR_WIDTH'(1);
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack and
// hands {instr, pc} to decode over valid/ready; accepts redirects from execute.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = WORD_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic            clk,
  input logic            rst,
  fetch_unit_if.master   bus
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_instr_q, out_instr_d;
  logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;

  pc_sel_e               pc_sel;
  logic [ADDR_WIDTH-1:0] pc_load;
  logic [ADDR_WIDTH-1:0] pc;

  fetch_unit_pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .sel     (pc_sel),
    .load_pc (pc_load),
    .pc      (pc)
  );

  always_comb begin
    state_d     = state_q;
    pend_pc_d   = pend_pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    pc_sel      = PcHold;
    pc_load     = bus.redirect_pc;

    case (state_q)
      StFetch: begin
        if (bus.imem_ack) begin
          if (bus.redirect_valid) begin
            pc_sel = PcLoad;
          end else begin
            out_valid_d = 1'b1;
            out_instr_d = bus.imem_rdata;
            out_pc_d    = pc;
            pc_sel      = PcIncr;
            state_d     = StValid;
          end
        end else if (bus.redirect_valid) begin
          // Request in flight: keep the address stable and remember the target.
          pend_pc_d = bus.redirect_pc;
          state_d   = StDrain;
        end
      end

      StDrain: begin
        if (bus.redirect_valid) begin
          pend_pc_d = bus.redirect_pc;
        end
        if (bus.imem_ack) begin
          pc_sel  = PcLoad;
          pc_load = bus.redirect_valid ? bus.redirect_pc : pend_pc_q;
          state_d = StFetch;
        end
      end

      StValid: begin
        // A transfer in the same cycle as a redirect still happens; decode squashes it.
        if (bus.redirect_valid) begin
          out_valid_d = 1'b0;
          pc_sel      = PcLoad;
          state_d     = StFetch;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StFetch;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = StFetch;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFetch;
      pend_pc_q   <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pend_pc_q   <= pend_pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  // Gated by rst so an ack landing in the reset cycle has no request to answer.
  assign bus.imem_req  = is_req_state(state_q) && !rst;
  assign bus.imem_addr = pc;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns rdata = addr + 8'hA0.
module tb_fetch_unit;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_unit #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (8'h10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] rd_lo;
  always_comb rd_lo = bus.imem_addr + 8'hA0;
  assign bus.imem_rdata = {24'h0, rd_lo};

  int errors = 0;
  int checks = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 8'h00;
    step();
    step();
    checks++; if (bus.imem_req !== 1'b0) begin errors++;
      $display("FAIL rst_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0 || bus.out_pc !== 8'h00) begin errors++;
      $display("FAIL rst_out: got %h/%h want 0/0", bus.out_instr, bus.out_pc); end
    checks++; if (bus.imem_addr !== 8'h10) begin errors++;
      $display("FAIL rst_addr: got %h want 10", bus.imem_addr); end
    rst = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h10) begin errors++;
      $display("FAIL first_req: got %b@%h want 1@10", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_stream();
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h10 ||
                  bus.out_instr !== 32'hB0) begin errors++;
      $display("FAIL stream0: got %b %h %h want 1 10 b0", bus.out_valid, bus.out_pc,
               bus.out_instr); end
    checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 8'h11) begin errors++;
      $display("FAIL stream0_req: got %b@%h want 0@11", bus.imem_req, bus.imem_addr); end
    step();
    checks++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b1 ||
                  bus.imem_addr !== 8'h11) begin errors++;
      $display("FAIL stream_gap: got v%b r%b@%h want v0 r1@11", bus.out_valid, bus.imem_req,
               bus.imem_addr); end
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h11 ||
                  bus.out_instr !== 32'hB1) begin errors++;
      $display("FAIL stream1: got %b %h %h want 1 11 b1", bus.out_valid, bus.out_pc,
               bus.out_instr); end
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h12) begin errors++;
      $display("FAIL stream_addr2: got %b@%h want 1@12", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h12 ||
                    bus.out_instr !== 32'hB2 || bus.imem_req !== 1'b0) begin errors++;
        $display("FAIL stall%0d: got v%b %h %h r%b want v1 12 b2 r0", i, bus.out_valid,
                 bus.out_pc, bus.out_instr, bus.imem_req); end
      if (i < 4) step();
    end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b1 ||
                  bus.imem_addr !== 8'h13) begin errors++;
      $display("FAIL stall_release: got v%b r%b@%h want v0 r1@13", bus.out_valid,
               bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_redirect_drain();
    bus.imem_ack = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'h40;
    step();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h13 ||
                    bus.out_valid !== 1'b0) begin errors++;
        $display("FAIL drain_hold%0d: got r%b@%h v%b want r1@13 v0", i, bus.imem_req,
                 bus.imem_addr, bus.out_valid); end
      step();
    end
    bus.imem_ack = 1'b1;
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h40 ||
                  bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL drain_target: got r%b@%h v%b want r1@40 v0", bus.imem_req,
               bus.imem_addr, bus.out_valid); end
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h40 ||
                  bus.out_instr !== 32'hE0) begin errors++;
      $display("FAIL drain_fetch: got %b %h %h want 1 40 e0", bus.out_valid, bus.out_pc,
               bus.out_instr); end
    step();
    // Second redirect during DRAIN: newest target wins.
    bus.imem_ack = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'h40;
    step();
    bus.redirect_pc = 8'h50;
    step();
    checks++; if (bus.imem_addr !== 8'h41) begin errors++;
      $display("FAIL drain2_hold: got %h want 41", bus.imem_addr); end
    bus.redirect_valid = 1'b0;
    bus.imem_ack = 1'b1;
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h50) begin errors++;
      $display("FAIL drain2_target: got r%b@%h want r1@50", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_redirect_ack();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'h20;
    step();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b1 ||
                  bus.imem_addr !== 8'h20) begin errors++;
      $display("FAIL redir_ack: got v%b r%b@%h want v0 r1@20", bus.out_valid, bus.imem_req,
               bus.imem_addr); end
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h20 ||
                  bus.out_instr !== 32'hC0) begin errors++;
      $display("FAIL redir_ack_fetch: got %b %h %h want 1 20 c0", bus.out_valid, bus.out_pc,
               bus.out_instr); end
    step();
  endtask

  task automatic test_wrap();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'hFF;
    step();
    bus.redirect_valid = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'hFF ||
                  bus.out_instr !== 32'h9F) begin errors++;
      $display("FAIL wrap_out: got %b %h %h want 1 ff 9f", bus.out_valid, bus.out_pc,
               bus.out_instr); end
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin errors++;
      $display("FAIL wrap_addr: got r%b@%h want r1@00", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_valid_redirect();
    bus.out_ready = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h00) begin errors++;
      $display("FAIL vred_pre: got %b %h want 1 00", bus.out_valid, bus.out_pc); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'h60;
    step();
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b1 ||
                  bus.imem_addr !== 8'h60) begin errors++;
      $display("FAIL vred_drop: got v%b r%b@%h want v0 r1@60", bus.out_valid, bus.imem_req,
               bus.imem_addr); end
  endtask

  task automatic test_reset_midop();
    // Reset while DRAIN is waiting; the ack in the reset cycle must be ignored.
    bus.imem_ack = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'h70;
    step();
    bus.redirect_valid = 1'b0;
    bus.imem_ack = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++;
      $display("FAIL drain_rst_req: got %b want 0", bus.imem_req); end
    step();
    checks++; if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0 ||
                  bus.out_instr !== 32'h0 || bus.imem_addr !== 8'h10) begin errors++;
      $display("FAIL drain_rst: got r%b v%b %h @%h want r0 v0 0 @10", bus.imem_req,
               bus.out_valid, bus.out_instr, bus.imem_addr); end
    rst = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h10) begin errors++;
      $display("FAIL drain_restart: got r%b@%h want r1@10", bus.imem_req, bus.imem_addr); end
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h10) begin errors++;
      $display("FAIL pre_valid_rst: got %b %h want 1 10", bus.out_valid, bus.out_pc); end
    rst = 1'b1;
    step();
    checks++; if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0 ||
                  bus.out_instr !== 32'h0 || bus.out_pc !== 8'h00 ||
                  bus.imem_addr !== 8'h10) begin errors++;
      $display("FAIL valid_rst: got r%b v%b %h %h @%h want r0 v0 0 00 @10", bus.imem_req,
               bus.out_valid, bus.out_instr, bus.out_pc, bus.imem_addr); end
    rst = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h10) begin errors++;
      $display("FAIL valid_restart: got r%b@%h want r1@10", bus.imem_req, bus.imem_addr); end
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h10 ||
                  bus.out_instr !== 32'hB0) begin errors++;
      $display("FAIL restart_fetch: got %b %h %h want 1 10 b0", bus.out_valid, bus.out_pc,
               bus.out_instr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_ack();
    test_wrap();
    test_valid_redirect();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
